arith_pipe: RTL and testbench

// - Parametrised, handshaked successor of the fixed 32-bit registered add/mul datapath.
// - Two-stage pipeline with four ops: ADD a+b, MUL a*b, ADD_MUL (a+b)*c and MAC acc+=a*b.
// - Full valid/ready flow control and an overflow flag; sustains one op per cycle.
// - Sits between an operand producer and a result consumer inside the arithmetic subsystem.
//

---
 rtl/arith_pkg.sv | 13 +
 rtl/arith_pipe_stage.sv | 42 ++++
 rtl/arith_pipe.sv | 135 +++++++++++++
 tb/tb_arith_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types for the handshaked add/mul/mac pipeline.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_MUL     = 2'd1,
        OP_ADD_MUL = 2'd2,
        OP_MAC     = 2'd3
    } op_e;

    localparam int OP_W = 2;

endpackage

// File: rtl/arith_pipe_stage.sv
// Generic valid/ready register slice: one entry, full throughput when the
// downstream side keeps draining.
module arith_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/arith_pipe.sv
// Two-stage ADD / MUL / ADD_MUL / MAC pipeline with valid/ready on both sides.
// Stage 1 pre-adds (or forwards a); stage 2 multiplies and owns the accumulator.
module arith_pipe
    import arith_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    typedef struct packed {
        op_e              op;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } s1_t;

    localparam int S1_W = $bits(s1_t);

    s1_t             s1_in, s1_q;
    logic [S1_W-1:0] s1_bits;
    logic            s1_valid, s1_ready;

    // MUL/MAC reuse the sum field to carry a into stage 2.
    always_comb begin
        s1_in.op = op;
        s1_in.b  = b;
        s1_in.c  = c;
        if (op == OP_MUL || op == OP_MAC) s1_in.sum = {1'b0, a};
        else                              s1_in.sum = {1'b0, a} + {1'b0, b};
    end

    arith_pipe_stage #(.DATA_W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_bits)
    );

    assign s1_q = s1_t'(s1_bits);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic               load;
    logic [WIDTH-1:0]   acc_base, mul_rhs, res;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH:0]   mac;
    logic               res_ovf;

    assign s1_ready = !out_valid_q || out_ready;
    assign load     = s1_valid && s1_ready;

    always_comb begin
        // A clear in the same cycle as a MAC load takes effect before the add.
        acc_base = acc_clr ? ACC_INIT : acc_q;
        mul_rhs  = (s1_q.op == OP_ADD_MUL) ? s1_q.c : s1_q.b;
        prod     = {{WIDTH{1'b0}}, s1_q.sum[WIDTH-1:0]} * {{WIDTH{1'b0}}, mul_rhs};
        mac      = {{(WIDTH+1){1'b0}}, acc_base} + {1'b0, prod};
        res      = s1_q.sum[WIDTH-1:0];
        res_ovf  = s1_q.sum[WIDTH];
        case (s1_q.op)
            OP_ADD: begin
                res     = s1_q.sum[WIDTH-1:0];
                res_ovf = s1_q.sum[WIDTH];
            end
            OP_MUL: begin
                res     = prod[WIDTH-1:0];
                res_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            OP_ADD_MUL: begin
                res     = prod[WIDTH-1:0];
                res_ovf = s1_q.sum[WIDTH] | (|prod[2*WIDTH-1:WIDTH]);
            end
            OP_MAC: begin
                res     = mac[WIDTH-1:0];
                res_ovf = |mac[2*WIDTH:WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        acc_d       = acc_base;
        if (load) begin
            out_valid_d = 1'b1;
            result_d    = res;
            ovf_d       = res_ovf;
            if (s1_q.op == OP_MAC) acc_d = res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Directed bench for arith_pipe: 32-bit instance plus an 8-bit instance with non-zero ACC_INIT.
module tb_arith_pipe;
    import arith_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, acc_clr = 1'b0, out_valid, out_ready = 1'b1, ovf;
    op_e         op = OP_ADD;
    logic [31:0] a = '0, b = '0, c = '0, result;

    logic        e_in_valid = 1'b0, e_in_ready, e_acc_clr = 1'b0, e_out_valid, e_out_ready = 1'b1, e_ovf;
    op_e         e_op = OP_ADD;
    logic [7:0]  e_a = '0, e_b = '0, e_c = '0, e_result;

    int total = 0;
    int bad   = 0;

    arith_pipe #(.WIDTH(32), .ACC_INIT(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .c(c), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    arith_pipe #(.WIDTH(8), .ACC_INIT(8'd10)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .op(e_op),
        .a(e_a), .b(e_b), .c(e_c), .acc_clr(e_acc_clr), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .result(e_result), .ovf(e_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input op_e o, input logic [31:0] ia, ib, ic,
                         input logic [31:0] er, input logic eo, input string tag);
        int n;
        op = o; a = ia; b = ib; c = ic; in_valid = 1'b1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 5) begin cyc(); n++; end
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        cyc();
    endtask

    task automatic do_op8(input op_e o, input logic [7:0] ia, ib, ic,
                          input logic [7:0] er, input logic eo, input string tag);
        int n;
        e_op = o; e_a = ia; e_b = ib; e_c = ic; e_in_valid = 1'b1;
        chk({tag, "_rdy"}, 64'(e_in_ready), 64'd1);
        cyc();
        e_in_valid = 1'b0;
        n = 0;
        while (!e_out_valid && n < 5) begin cyc(); n++; end
        chk({tag, "_vld"}, 64'(e_out_valid), 64'd1);
        chk({tag, "_res"}, 64'(e_result), 64'(er));
        chk({tag, "_ovf"}, 64'(e_ovf), 64'(eo));
        cyc();
    endtask

    // Reference: returns {ovf, result}; acc is advanced in acceptance order.
    function automatic logic [32:0] model(input op_e o, input logic [31:0] x, y, z,
                                          inout logic [31:0] acc);
        logic [32:0] s;
        logic [63:0] p;
        logic [64:0] q;
        s = {1'b0, x} + {1'b0, y};
        case (o)
            OP_ADD:     return s;
            OP_MUL: begin
                p = {32'd0, x} * {32'd0, y};
                return {|p[63:32], p[31:0]};
            end
            OP_ADD_MUL: begin
                p = {32'd0, s[31:0]} * {32'd0, z};
                return {s[32] | (|p[63:32]), p[31:0]};
            end
            default: begin
                p = {32'd0, x} * {32'd0, y};
                q = {33'd0, acc} + {1'b0, p};
                acc = q[31:0];
                return {|q[64:32], q[31:0]};
            end
        endcase
    endfunction

    // mode 0: 8 ADD beats i+i, out_ready low for the first 4 cycles.
    // mode 1: random in_valid/out_ready and random mixed ops.
    task automatic stream(input int nbeats, input int mode);
        logic [32:0] expq[$];
        logic [32:0] held, e;
        logic [31:0] macc;
        logic        hold;
        int sent, got, n;
        sent = 0; got = 0; n = 0; hold = 1'b0; held = '0; macc = 32'd0;
        while (got < nbeats && n < 20 * nbeats + 100) begin
            if (sent < nbeats) begin
                if (mode == 0) begin
                    in_valid = 1'b1; op = OP_ADD; a = 32'(sent); b = 32'(sent); c = '0;
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                    op = op_e'($urandom_range(0, 3));
                    a = $urandom; b = $urandom; c = $urandom;
                    if ($urandom_range(0, 1) == 1) begin a &= 32'hFFFF; b &= 32'hFFFF; c &= 32'hFF; end
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (mode == 0) ? (n >= 4) : 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                chk("stall_vld", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'({ovf, result}), 64'(held));
            end
            if (out_valid && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : 33'h1_DEAD_BEEF;
                chk("stream_out", 64'({ovf, result}), 64'(e));
                got++;
            end
            hold = out_valid && !out_ready;
            held = {ovf, result};
            if (in_valid && in_ready) begin
                if (mode == 0) expq.push_back({1'b0, 32'(2 * sent)});
                else           expq.push_back(model(op, a, b, c, macc));
                sent++;
            end
            if (mode == 0 && n == 3) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepted", 64'(sent), 64'd2);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(nbeats));
        chk("stream_left", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with a beat offered
        in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_vld", 64'(out_valid), 64'd0);
            chk("rst_res", 64'(result), 64'd0);
            chk("rst_ovf", 64'(ovf), 64'd0);
        end
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("lat_n1", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_n2_vld", 64'(out_valid), 64'd1);
        chk("lat_n2_res", 64'(result), 64'd2);
        cyc();

        do_op(OP_ADD,     32'd5,          32'd7,       32'd0, 32'd12, 1'b0, "add");
        do_op(OP_ADD,     32'hFFFF_FFFF,  32'd1,       32'd0, 32'd0,  1'b1, "add_ovf");
        do_op(OP_MUL,     32'h1_0000,     32'h1_0000,  32'd0, 32'd0,  1'b1, "mul_ovf");
        do_op(OP_MUL,     32'd7,          32'd6,       32'd9, 32'd42, 1'b0, "mul");
        do_op(OP_ADD_MUL, 32'd3,          32'd4,       32'd5, 32'd35, 1'b0, "addmul");

        // MAC chain after a clear pulse
        acc_clr = 1'b1; cyc(); acc_clr = 1'b0;
        op = OP_MAC; a = 32'd2; b = 32'd3; in_valid = 1'b1; cyc();
        a = 32'd4; b = 32'd5; cyc();
        chk("mac1", 64'({out_valid, ovf, result}), {31'd0, 1'b1, 1'b0, 32'd6});
        a = 32'd1; b = 32'd1; cyc();
        chk("mac2", 64'({out_valid, ovf, result}), {31'd0, 1'b1, 1'b0, 32'd26});
        in_valid = 1'b0; cyc();
        chk("mac3", 64'({out_valid, ovf, result}), {31'd0, 1'b1, 1'b0, 32'd27});
        a = 32'd0; b = 32'd0; in_valid = 1'b1; cyc();
        in_valid = 1'b0; acc_clr = 1'b1; cyc(); acc_clr = 1'b0;
        chk("mac_clr_load", 64'({out_valid, ovf, result}), {31'd0, 1'b1, 1'b0, 32'd0});
        cyc();
        do_op(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, "add_keeps_acc");
        do_op(OP_MAC, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, "mac_after_add");

        stream(8, 0);

        acc_clr = 1'b1; cyc(); acc_clr = 1'b0;
        stream(2000, 1);

        // Mid-stream reset with S1 and output both full on both instances
        cyc();
        out_ready = 1'b0; e_out_ready = 1'b0;
        op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        e_op = OP_ADD; e_a = 8'd1; e_b = 8'd1; e_in_valid = 1'b1;
        cyc(); cyc();
        in_valid = 1'b0; e_in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_vld", 64'(out_valid), 64'd1);
        chk("full8_in_ready", 64'(e_in_ready), 64'd0);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("mrst_vld", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst8_vld", 64'(e_out_valid), 64'd0);
        out_ready = 1'b1; e_out_ready = 1'b1;
        cyc(); cyc();
        chk("mrst_s1_dropped", 64'(out_valid), 64'd0);
        chk("mrst8_s1_dropped", 64'(e_out_valid), 64'd0);
        do_op(OP_MAC, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, "mrst_mac");
        do_op8(OP_MAC, 8'd2, 8'd2, 8'd0, 8'd14, 1'b0, "w8_mac");
        do_op8(OP_MAC, 8'd16, 8'd16, 8'd0, 8'd14, 1'b1, "w8_mac_ovf");
        do_op8(OP_ADD_MUL, 8'd200, 8'd100, 8'd2, 8'd88, 1'b1, "w8_addmul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
